// File: rtl/data_mem_ctrl.sv
// Data memory controller: single-port word memory behind a valid/ready request
// interface with byte/halfword/word access, sign/zero extension on loads,
// alignment and range checking, and a configurable response latency.
module data_mem_ctrl #(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] ADDR_LIM = 32'(4 * DEPTH);
    localparam logic [2:0]  LAT_LAST = 3'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [2:0]    r_cnt;
    logic [2:0]    w_cnt_next;

    logic          r_we;
    logic [31:0]   r_addr;
    logic [1:0]    r_size;
    logic          r_signed;
    logic [31:0]   r_wdata;

    logic          r_ready;
    logic          r_resp_valid;
    logic [31:0]   r_resp_rdata;
    logic          r_resp_err;

    // Contents start at zero and are deliberately untouched by rst.
    logic [31:0]   r_mem [0:DEPTH-1] = '{default: 32'h0000_0000};

    logic          w_accept;
    logic          w_enter_resp;
    logic          w_op_we;
    logic [31:0]   w_op_addr;
    logic [1:0]    w_op_size;
    logic          w_op_signed;
    logic [31:0]   w_op_wdata;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic [4:0]    w_shamt;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata_sh;
    logic [31:0]   w_rd_word;
    logic [31:0]   w_load_data;

    // Misaligned, illegal-size and out-of-range accesses are all rejected.
    function automatic logic calc_err(input logic [1:0] size, input logic [31:0] addr);
        logic e;
        case (size)
            2'b00:   e = 1'b0;
            2'b01:   e = addr[0];
            2'b10:   e = (addr[1:0] != 2'b00);
            default: e = 1'b1;
        endcase
        return e | (addr >= ADDR_LIM);
    endfunction

    // Pick the addressed lanes out of a memory word and extend to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [4:0] shamt,
                                                 input logic [1:0] size, input logic sgn);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> shamt;
        case (size)
            2'b00:   res = sgn ? {{24{sh[7]}}, sh[7:0]}   : {24'h00_0000, sh[7:0]};
            2'b01:   res = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0000, sh[15:0]};
            2'b10:   res = sh;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    assign w_accept     = (r_state == IDLE) && req_valid;
    assign w_enter_resp = (w_next_state == RESP) && (r_state != RESP);

    // With zero latency the access happens on the acceptance edge, so the live
    // request inputs are used in IDLE and the captured copy everywhere else.
    always_comb begin
        w_op_we     = r_we;
        w_op_addr   = r_addr;
        w_op_size   = r_size;
        w_op_signed = r_signed;
        w_op_wdata  = r_wdata;
        if (r_state == IDLE) begin
            w_op_we     = req_we;
            w_op_addr   = req_addr;
            w_op_size   = req_size;
            w_op_signed = req_signed;
            w_op_wdata  = req_wdata;
        end else begin
            w_op_we     = r_we;
            w_op_addr   = r_addr;
            w_op_size   = r_size;
            w_op_signed = r_signed;
            w_op_wdata  = r_wdata;
        end
    end

    assign w_err       = calc_err(w_op_size, w_op_addr);
    assign w_idx       = w_op_addr[AW+1:2];
    assign w_shamt     = {w_op_addr[1:0], 3'b000};
    assign w_wdata_sh  = w_op_wdata << w_shamt;
    assign w_rd_word   = r_mem[w_idx];
    assign w_load_data = load_extract(w_rd_word, w_shamt, w_op_size, w_op_signed);

    // Byte enables for a store, shifted to the addressed lane.
    always_comb begin
        w_be = 4'b0000;
        case (w_op_size)
            2'b00:   w_be = 4'b0001 << w_op_addr[1:0];
            2'b01:   w_be = 4'b0011 << w_op_addr[1:0];
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // Next-state and wait-counter logic.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_next_state = (LATENCY == 0) ? RESP : WAIT;
                    w_cnt_next   = 3'd0;
                end else begin
                    w_next_state = IDLE;
                    w_cnt_next   = 3'd0;
                end
            end
            WAIT: begin
                if (r_cnt == LAT_LAST) begin
                    w_next_state = RESP;
                    w_cnt_next   = 3'd0;
                end else begin
                    w_next_state = WAIT;
                    w_cnt_next   = r_cnt + 3'd1;
                end
            end
            RESP: begin
                w_next_state = IDLE;
                w_cnt_next   = 3'd0;
            end
            default: begin
                w_next_state = IDLE;
                w_cnt_next   = 3'd0;
            end
        endcase
    end

    // State, request capture and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= 3'd0;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0000_0000;
            r_resp_err   <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= 32'h0000_0000;
            r_size       <= 2'b00;
            r_signed     <= 1'b0;
            r_wdata      <= 32'h0000_0000;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_cnt_next;
            r_ready      <= (w_next_state == IDLE);
            r_resp_valid <= w_enter_resp;
            if (w_enter_resp) begin
                r_resp_err   <= w_err;
                r_resp_rdata <= (w_err || w_op_we) ? 32'h0000_0000 : w_load_data;
            end else begin
                r_resp_err   <= 1'b0;
                r_resp_rdata <= 32'h0000_0000;
            end
            if (w_accept) begin
                r_we     <= req_we;
                r_addr   <= req_addr;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_wdata  <= req_wdata;
            end else begin
                r_we     <= r_we;
                r_addr   <= r_addr;
                r_size   <= r_size;
                r_signed <= r_signed;
                r_wdata  <= r_wdata;
            end
        end
    end

    // Store lanes on the edge that enters RESP; a reset on that edge cancels it.
    always_ff @(posedge clk) begin
        if (!rst && w_enter_resp && w_op_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][i*8 +: 8] <= w_wdata_sh[i*8 +: 8];
                end
            end
        end
    end

    assign req_ready  = r_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule
